// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a small byte FIFO behind a one-word memory-mapped
// register: status flags and head byte on out, pop/clear commands through in.
module uart_rx_fifo #(
   parameter int unsigned BAUD_DIV = 217,
   parameter int unsigned DEPTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RX,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 16;
   localparam logic [TW-1:0] FULL_BIT = TW'(BAUD_DIV);
   localparam logic [TW-1:0] HALF_BIT = TW'(BAUD_DIV / 2);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   logic          rx_meta;
   logic          rxs;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          ovr_flag;
   logic          frm_flag;

   logic          tick_c;
   logic          push_c;
   logic          frm_set_c;
   logic          pop_c;
   logic          push_ok_c;
   logic          ovr_set_c;
   logic          clr_c;
   logic          empty_c;
   logic          unused_in;

   assign unused_in = ^in[15:2];

   // Two-flop synchronizer; idle level is high so the flops reset to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RX;
         rxs     <= rx_meta;
      end
   end

   // A timer value of 1 means this edge is the sampling point.
   assign tick_c    = (timer <= TW'(1));
   assign push_c    = (state == S_STOP) && tick_c && rxs;
   assign frm_set_c = (state == S_STOP) && tick_c && !rxs;

   // Receiver: start-bit qualification at half a bit, then full-bit sampling.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state <= S_START;
                  timer <= HALF_BIT;
               end
            end
            S_START: begin
               if (tick_c) begin
                  if (!rxs) begin
                     state   <= S_DATA;
                     timer   <= FULL_BIT;
                     bit_idx <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  shreg   <= {rxs, shreg[7:1]};
                  timer   <= FULL_BIT;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_STOP: begin
               if (tick_c) state <= rxs ? S_IDLE : S_BREAK;
               else        timer <= timer - TW'(1);
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign empty_c   = (count == '0);
   assign pop_c     = load && in[0] && !empty_c;
   assign clr_c     = load && in[1];
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok_c = push_c && ((count != FULL_CNT) || pop_c);
   assign ovr_set_c = push_c && (count == FULL_CNT) && !pop_c;

   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         ovr_flag <= 1'b0;
         frm_flag <= 1'b0;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Set has priority over a clear in the same cycle.
         ovr_flag <= ovr_set_c || (ovr_flag && !clr_c);
         frm_flag <= frm_set_c || (frm_flag && !clr_c);
      end
   end

   assign out = {empty_c, ovr_flag, frm_flag, 5'b0, empty_c ? 8'h00 : mem[rd_ptr]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=8, DEPTH=4; one task per scenario.
module tb_uart_rx_fifo;

   localparam int unsigned BD = 8;

   logic        clk;
   logic        reset;
   logic        rx;
   logic        load;
   logic [15:0] in_w;
   logic [15:0] out_w;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(.BAUD_DIV(BD), .DEPTH(4)) dut (
      .clk  (clk),
      .reset(reset),
      .RX   (rx),
      .load (load),
      .in   (in_w),
      .out  (out_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_head(input logic [7:0] b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_head(b);
      drive_bit(1'b1);
      drive_bit(1'b1);
   endtask

   task automatic do_write(input logic [15:0] v);
      load = 1'b1;
      in_w = v;
      @(negedge clk);
      load = 1'b0;
      in_w = 16'h0000;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL reset_held: out=%h expected=%h", out_w, 16'h8000);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL reset_released: out=%h expected=%h", out_w, 16'h8000);
      end
   endtask

   task automatic test_basic();
      apply_reset();
      send_head(8'hA5);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL basic_before_stop: out=%h expected=%h", out_w, 16'h8000);
      end
      rx = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL basic_edge_before_sample: out=%h expected=%h", out_w, 16'h8000);
      end
      @(negedge clk);
      checks++;
      if (out_w !== 16'h00A5) begin
         errors++;
         $display("FAIL basic_after_sample: out=%h expected=%h", out_w, 16'h00A5);
      end
      @(negedge clk);
      drive_bit(1'b1);
      checks++;
      if (out_w !== 16'h00A5) begin
         errors++;
         $display("FAIL basic_hold: out=%h expected=%h", out_w, 16'h00A5);
      end
      do_write(16'h0001);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL basic_pop: out=%h expected=%h", out_w, 16'h8000);
      end
   endtask

   task automatic test_overrun();
      logic [15:0] exp_pop [4];
      exp_pop[0] = 16'h4022;
      exp_pop[1] = 16'h4033;
      exp_pop[2] = 16'h4044;
      exp_pop[3] = 16'hC000;
      apply_reset();
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      checks++;
      if (out_w !== 16'h4011) begin
         errors++;
         $display("FAIL overrun_set: out=%h expected=%h", out_w, 16'h4011);
      end
      for (int i = 0; i < 4; i++) begin
         do_write(16'h0001);
         checks++;
         if (out_w !== exp_pop[i]) begin
            errors++;
            $display("FAIL overrun_pop%0d: out=%h expected=%h", i, out_w, exp_pop[i]);
         end
      end
      do_write(16'h0002);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL overrun_clear: out=%h expected=%h", out_w, 16'h8000);
      end
   endtask

   task automatic test_framing();
      apply_reset();
      send_head(8'h3C);
      rx = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL framing_before_sample: out=%h expected=%h", out_w, 16'h8000);
      end
      // Clear lands on the same edge that sets the framing flag.
      do_write(16'h0002);
      checks++;
      if (out_w !== 16'hA000) begin
         errors++;
         $display("FAIL framing_set_wins: out=%h expected=%h", out_w, 16'hA000);
      end
      repeat (17) @(negedge clk);
      checks++;
      if (out_w !== 16'hA000) begin
         errors++;
         $display("FAIL framing_break: out=%h expected=%h", out_w, 16'hA000);
      end
      drive_bit(1'b1);
      send_byte(8'h7E);
      checks++;
      if (out_w !== 16'h207E) begin
         errors++;
         $display("FAIL framing_next_byte: out=%h expected=%h", out_w, 16'h207E);
      end
      do_write(16'h0002);
      checks++;
      if (out_w !== 16'h007E) begin
         errors++;
         $display("FAIL framing_clear: out=%h expected=%h", out_w, 16'h007E);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL glitch_ignored: out=%h expected=%h", out_w, 16'h8000);
      end
      send_byte(8'hC3);
      checks++;
      if (out_w !== 16'h00C3) begin
         errors++;
         $display("FAIL glitch_then_frame: out=%h expected=%h", out_w, 16'h00C3);
      end
   endtask

   task automatic test_full_pop();
      logic [15:0] exp_pop [4];
      exp_pop[0] = 16'h0003;
      exp_pop[1] = 16'h0004;
      exp_pop[2] = 16'h0005;
      exp_pop[3] = 16'h8000;
      apply_reset();
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      checks++;
      if (out_w !== 16'h0001) begin
         errors++;
         $display("FAIL full_head: out=%h expected=%h", out_w, 16'h0001);
      end
      send_head(8'h05);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      // Pop coincides with the fifth push while full.
      do_write(16'h0001);
      checks++;
      if (out_w !== 16'h0002) begin
         errors++;
         $display("FAIL full_push_pop: out=%h expected=%h", out_w, 16'h0002);
      end
      @(negedge clk);
      drive_bit(1'b1);
      for (int i = 0; i < 4; i++) begin
         do_write(16'h0001);
         checks++;
         if (out_w !== exp_pop[i]) begin
            errors++;
            $display("FAIL full_pop%0d: out=%h expected=%h", i, out_w, exp_pop[i]);
         end
      end
      do_write(16'h0001);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL empty_pop: out=%h expected=%h", out_w, 16'h8000);
      end
      send_byte(8'h66);
      checks++;
      if (out_w !== 16'h0066) begin
         errors++;
         $display("FAIL after_empty_pop: out=%h expected=%h", out_w, 16'h0066);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'h99;
      apply_reset();
      send_byte(8'h10);
      send_byte(8'h20);
      checks++;
      if (out_w !== 16'h0010) begin
         errors++;
         $display("FAIL midreset_queued: out=%h expected=%h", out_w, 16'h0010);
      end
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rx = b[4];
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL midreset_immediate: out=%h expected=%h", out_w, 16'h8000);
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (out_w !== 16'h8000) begin
         errors++;
         $display("FAIL midreset_idle: out=%h expected=%h", out_w, 16'h8000);
      end
      send_byte(8'h5A);
      checks++;
      if (out_w !== 16'h005A) begin
         errors++;
         $display("FAIL midreset_next_frame: out=%h expected=%h", out_w, 16'h005A);
      end
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      load  = 1'b0;
      in_w  = 16'h0000;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overrun();
      test_framing();
      test_glitch();
      test_full_pop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 217, clk cycles per bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RX  input  1  serial receive pin; asynchronous to clk; idle high.
REQ-006 SHALL have port load  input  1  memory-map write strobe, one cycle.
REQ-007 SHALL have port in  input  16  write data; in[0]=1 pops the head byte; in[1]=1 clears the error flags; other bits are ignored.
REQ-008 SHALL have port out  output  16  memory-map read word.
  - [15]=1: FIFO empty.
  - [14]: overrun flag.
  - [13]: framing-error flag.
  - [12:8]: zero.
  - [7:0]: head byte, or 0 when empty.

Function
REQ-009 SHALL pass RX through a 2-flop synchronizer (flops reset to 1) and use only the synchronized value, rxs.
REQ-010 SHALL run receiver FSM states IDLE, START, DATA, STOP, BREAK with a bit-timer counter and a 3-bit bit index.
REQ-011 IDLE: on rxs=0, go to START with timer = BAUD_DIV/2 (integer division).
REQ-012 START: when the timer expires, go to DATA with timer = BAUD_DIV if rxs=0; otherwise return to IDLE (glitch, nothing recorded).
REQ-013 DATA: sample rxs each time the timer expires (reload BAUD_DIV); bits are LSB first; go to STOP with timer = BAUD_DIV after the 8th sample.
REQ-014 STOP: when the timer expires, rxs=1 pushes the byte and goes to IDLE; rxs=0 discards the byte, sets the framing flag, and goes to BREAK.
REQ-015 BREAK: go to IDLE when rxs=1.
REQ-016 A pushed byte SHALL appear on out the cycle after the STOP sample edge, if the FIFO was empty.
REQ-017 FIFO: circular buffer with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-018 A push while full (count=DEPTH) with no simultaneous pop SHALL drop the byte, set the overrun flag, and leave contents unchanged.
REQ-019 A pop (load & in[0]) SHALL advance the read pointer; a pop while empty SHALL be ignored.
REQ-020 A simultaneous push and pop when non-empty SHALL perform both, leaving count unchanged, including when full.
REQ-021 A simultaneous push and pop when empty SHALL perform the push only.
REQ-022 Error flags SHALL be sticky; load & in[1] clears both.
REQ-023 If a flag set and a clear occur in the same cycle, the set SHALL win.
REQ-024 Pop and clear in the same write SHALL both take effect.
REQ-025 out SHALL be combinational from registered state only, with no path from in or load.

Reset
REQ-026 Asserting reset at any time, including mid-frame, SHALL immediately apply:
  - FSM to IDLE;
  - timer, bit index, pointers, count and flags to 0;
  - synchronizer flops to 1;
  - out = 0x8000.
REQ-027 After reset deasserts, a frame in progress SHALL be handled as follows:
  - if the line is high, it is ignored;
  - if the line is low, it starts a new START check, which glitch-rejects or frames normally.

Verification (BAUD_DIV=8, DEPTH=4)
REQ-028 Reset, then send 0xA5 8N1 -> out=0x8000 until the stop sample, then 0x00A5; write in=0x0001 -> out=0x8000.
REQ-029 Send 0x11, 0x22, 0x33, 0x44, 0x55 without popping -> out=0x4011 (overrun set); four pops read 0x11, 0x22, 0x33, 0x44, then out=0xC000.
REQ-030 Frame 0x3C with stop bit held 0 for 3 bit times, then 0x7E -> out=0x207E; write in=0x0002 -> out=0x007E.
REQ-031 RX low pulse of 2 clk from idle -> FSM returns to IDLE, out stays 0x8000, flags 0.
REQ-032 FIFO full (4 bytes), pop on the same cycle as the 5th push -> no overrun, count=4, order preserved; pop on empty -> no change.
REQ-033 Assert reset during DATA bit 4 with 2 bytes queued -> out=0x8000 immediately; next full frame 0x5A is received correctly.
